// File: rtl/andor_seq_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : andor_seq_checker_if
//  Description : Bundle between the AND/OR sequencing checker and its
//                environment. The master side (the checker) drives the X/Y
//                operands and the status outputs. The slave side (environment
//                plus AND/OR block) drives start and the XandY/XorY results.
//  Signals     : start     - begin a sweep
//                X, Y      - operands to the AND/OR block
//                XandY     - AND result returned by the block
//                XorY      - OR result returned by the block
//                busy      - sweep in progress
//                done      - sweep finished
//                pass      - sweep clean (valid with done)
//                err_count - mismatching vectors in current/last sweep
//                fail_vec  - first mismatching vector, {X,Y}
//  Revision    : 1.0 - initial release
// ============================================================================
interface andor_seq_checker_if #(
  parameter int WIDTH = 2
);
  logic                 start;
  logic [WIDTH-1:0]     X;
  logic [WIDTH-1:0]     Y;
  logic [WIDTH-1:0]     XandY;
  logic [WIDTH-1:0]     XorY;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [2*WIDTH:0]     err_count;
  logic [2*WIDTH-1:0]   fail_vec;

  modport master (
    input  start, XandY, XorY,
    output X, Y, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    output start, XandY, XorY,
    input  X, Y, busy, done, pass, err_count, fail_vec
  );
endinterface
`default_nettype wire

// File: rtl/andor_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : andor_seq_checker
//  Description : Sweeps every X/Y operand combination into a WIDTH-bit AND/OR
//                block, waits SETTLE cycles per vector, then checks XandY and
//                XorY against X&Y and X|Y. Counts mismatches, remembers the
//                first failing vector and reports done/pass.
//  Parameters  : WIDTH  - operand width (must match the interface WIDTH)
//                SETTLE - cycles between applying a vector and sampling (>=1)
//  Ports       : clk    - system clock, rising edge
//                rst    - synchronous active-high reset
//                bus    - andor_seq_checker_if master modport
//  Build macro : ANDOR_SEQ_STOP_ON_ERR_EN - when defined, the first mismatch
//                ends the sweep immediately with X/Y holding the failing
//                vector. Undefined: the full sweep always completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module andor_seq_checker #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  wire logic            clk,
  input  wire logic            rst,
  andor_seq_checker_if.master  bus
);

  localparam int c_idxW = 2 * WIDTH;
  localparam int c_errW = 2 * WIDTH + 1;
  localparam int c_cntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [c_cntW-1:0] c_settleLoad = c_cntW'(SETTLE - 1);
  localparam logic [c_idxW-1:0] c_lastIdx    = {c_idxW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_idxW-1:0]   r_idx;
  logic [c_cntW-1:0]   r_settleCnt;
  logic [c_errW-1:0]   r_errCount;
  logic [c_idxW-1:0]   r_failVec;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;

  logic [WIDTH-1:0]    w_x;
  logic [WIDTH-1:0]    w_y;
  logic                w_mismatch;
  logic                w_stop;
  logic [c_errW-1:0]   w_errNext;

  // Operands are the two halves of the registered vector index
  assign w_x = r_idx[c_idxW-1:WIDTH];
  assign w_y = r_idx[WIDTH-1:0];

  // Only consumed in CHECK, so unknowns on the results elsewhere are harmless
  assign w_mismatch = (bus.XandY != (w_x & w_y)) || (bus.XorY != (w_x | w_y));
  assign w_errNext  = r_errCount + c_errW'(w_mismatch);

`ifdef ANDOR_SEQ_STOP_ON_ERR_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_settleCnt <= '0;
      r_errCount  <= '0;
      r_failVec   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state     <= S_SETTLE;
            r_idx       <= '0;
            r_errCount  <= '0;
            r_failVec   <= '0;
            r_settleCnt <= c_settleLoad;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
          end
        end

        S_SETTLE: begin
          if (r_settleCnt == '0) begin
            r_state <= S_CHECK;
          end else begin
            r_settleCnt <= r_settleCnt - c_cntW'(1);
          end
        end

        S_CHECK: begin
          if (w_mismatch) begin
            r_errCount <= w_errNext;
            // Zero count before this vector means it is the first failure
            if (r_errCount == '0) begin
              r_failVec <= r_idx;
            end
          end
          if ((r_idx == c_lastIdx) || w_stop) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_errNext == '0);
          end else begin
            r_idx       <= r_idx + c_idxW'(1);
            r_settleCnt <= c_settleLoad;
            r_state     <= S_SETTLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.X         = w_x;
  assign bus.Y         = w_y;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.err_count = r_errCount;
  assign bus.fail_vec  = r_failVec;

endmodule
`default_nettype wire

// File: tb/tb_andor_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_andor_seq_checker
//  Description : Self-checking bench for andor_seq_checker. Two instances
//                (SETTLE=1 and SETTLE=3) share a faultable AND/OR model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_andor_seq_checker;

  logic clk;
  logic rst;

  // Fault plant: set bits force 1, clear bits force 0 (clear wins)
  logic [1:0] andClr, andSet, orClr, orSet;

  andor_seq_checker_if #(.WIDTH(2)) bus1 ();
  andor_seq_checker_if #(.WIDTH(2)) bus3 ();

  assign bus1.XandY = ((bus1.X & bus1.Y) | andSet) & ~andClr;
  assign bus1.XorY  = ((bus1.X | bus1.Y) | orSet)  & ~orClr;
  assign bus3.XandY = ((bus3.X & bus3.Y) | andSet) & ~andClr;
  assign bus3.XorY  = ((bus3.X | bus3.Y) | orSet)  & ~orClr;

  andor_seq_checker #(.WIDTH(2), .SETTLE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  andor_seq_checker #(.WIDTH(2), .SETTLE(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err;
    logic [3:0] fv;
    logic [1:0] x;
    logic [1:0] y;
  } obs_t;

  typedef struct {
    logic [1:0] aC, aS, oC, oS;
    int         expErr;
    int         expFail;
  } vec_t;

  vec_t tbl[6];

  function automatic obs_t getObs(input int sel);
    obs_t o;
    if (sel == 3) o = {bus3.busy, bus3.done, bus3.pass, bus3.err_count, bus3.fail_vec, bus3.X, bus3.Y};
    else          o = {bus1.busy, bus1.done, bus1.pass, bus1.err_count, bus1.fail_vec, bus1.X, bus1.Y};
    return o;
  endfunction

  task automatic setStart(input int sel, input logic v);
    if (sel == 3) bus3.start = v;
    else          bus1.start = v;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full-sweep totals from the rules: test every vector against a faulted block
  function automatic void refModel(input logic [1:0] aC, aS, oC, oS,
                                   output int err, output int fail);
    logic [1:0] x, y, gA, gO;
    err  = 0;
    fail = 0;
    for (int v = 0; v < 16; v++) begin
      x  = 2'(v >> 2);
      y  = 2'(v & 3);
      gA = x & y;
      gO = x | y;
      if ((((gA | aS) & ~aC) != gA) || (((gO | oS) & ~oC) != gO)) begin
        if (err == 0) fail = v;
        err++;
      end
    end
  endfunction

  // Turn full-sweep totals into what this build reports and when
  function automatic void derive(input int e, input int f, input int settle,
                                 output int expErr, output int doneAt, output int finalIdx);
    expErr   = e;
    doneAt   = 16 * (settle + 1);
    finalIdx = 15;
`ifdef ANDOR_SEQ_STOP_ON_ERR_EN
    if (e > 0) begin
      expErr   = 1;
      doneAt   = (f + 1) * (settle + 1);
      finalIdx = f;
    end
`endif
  endfunction

  task automatic runSweep(input int sel, input int settle, input int pokeAt, input int resetAt,
                          input int expErr, input int expFail, input int doneAt, input int finalIdx);
    obs_t o;
    obs_t e;
    int   idx;
    @(negedge clk);
    setStart(sel, 1'b1);
    @(posedge clk);
    #1 setStart(sel, 1'b0);
    for (int k = 0; k <= doneAt; k++) begin
      @(negedge clk);
      if (k == pokeAt + 1) setStart(sel, 1'b0);
      o = getObs(sel);
      if (k < doneAt) begin
        idx = k / (settle + 1);
        check($sformatf("sweep%0d k=%0d busy/done/pass/XY", sel, k),
              {60'd0, o.busy, o.done, o.pass, o.x, o.y},
              {60'd0, 1'b1, 1'b0, 1'b0, 2'(idx >> 2), 2'(idx & 3)});
      end else begin
        e      = '0;
        e.done = 1'b1;
        e.pass = (expErr == 0);
        e.err  = 5'(expErr);
        e.fv   = 4'(expFail);
        e.x    = 2'(finalIdx >> 2);
        e.y    = 2'(finalIdx & 3);
        check($sformatf("sweep%0d done outputs", sel), 64'(o), 64'(e));
        @(negedge clk);
        check($sformatf("sweep%0d done held", sel), 64'(getObs(sel)), 64'(e));
      end
      if (k == resetAt) begin
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check($sformatf("sweep%0d mid-sweep reset", sel), 64'(getObs(sel)), 64'd0);
        @(negedge clk);
        check($sformatf("sweep%0d idle after reset", sel), 64'(getObs(sel)), 64'd0);
        return;
      end
      if (k == pokeAt) setStart(sel, 1'b1);
    end
  endtask

  initial begin
    int e, f, xe, da, fi, sel, st;

    tbl[0] = '{aC:2'b00, aS:2'b00, oC:2'b00, oS:2'b00, expErr:0,  expFail:0};
    tbl[1] = '{aC:2'b00, aS:2'b00, oC:2'b01, oS:2'b00, expErr:12, expFail:1};
    tbl[2] = '{aC:2'b00, aS:2'b01, oC:2'b00, oS:2'b00, expErr:12, expFail:0};
    tbl[3] = '{aC:2'b10, aS:2'b00, oC:2'b00, oS:2'b00, expErr:4,  expFail:10};
    tbl[4] = '{aC:2'b00, aS:2'b00, oC:2'b00, oS:2'b11, expErr:7,  expFail:0};
    tbl[5] = '{aC:2'b01, aS:2'b00, oC:2'b10, oS:2'b00, expErr:13, expFail:2};

    andClr = '0; andSet = '0; orClr = '0; orSet = '0;
    rst = 1'b1;
    bus1.start = 1'b1;
    bus3.start = 1'b1;

    // Reset held with start asserted: everything stays at zero
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("reset dut1 c=%0d", c), 64'(getObs(1)), 64'd0);
      check($sformatf("reset dut3 c=%0d", c), 64'(getObs(3)), 64'd0);
    end
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle after reset", 64'(getObs(1)), 64'd0);

    // Healthy sweep with a stray start at cycle 5
    runSweep(1, 1, 5, -1, 0, 0, 32, 15);

    // Table of faults, each sweep restarted from DONE
    for (int i = 0; i < 6; i++) begin
      andClr = tbl[i].aC; andSet = tbl[i].aS; orClr = tbl[i].oC; orSet = tbl[i].oS;
      derive(tbl[i].expErr, tbl[i].expFail, 1, xe, da, fi);
      runSweep(1, 1, -5, -1, xe, tbl[i].expFail, da, fi);
    end

    // Reset in the middle of a sweep
    andClr = '0; andSet = '0; orClr = '0; orSet = '0;
    runSweep(1, 1, -5, 10, 0, 0, 32, 15);

    // Longer settle, healthy
    runSweep(3, 3, -5, -1, 0, 0, 64, 15);

    // Random faults against the reference model
    for (int r = 0; r < 12; r++) begin
      andClr = 2'($urandom & $urandom);
      andSet = 2'($urandom & $urandom);
      orClr  = 2'($urandom & $urandom);
      orSet  = 2'($urandom & $urandom);
      sel    = ($urandom_range(0, 1) == 1) ? 3 : 1;
      st     = (sel == 3) ? 3 : 1;
      refModel(andClr, andSet, orClr, orSet, e, f);
      derive(e, f, st, xe, da, fi);
      runSweep(sel, st, int'($urandom_range(0, da - 1)), -1, xe, f, da, fi);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
